fixed_point_muldiv_seq: RTL and testbench
=========================================

# fixed_point_muldiv_seq

Sequential signed binary fixed-point multiply/divide unit for the raycaster datapath. It replaces the per-operation combinational decimal-fraction multipliers and dividers with a single parametrised Q(INT_W).(FRAC_W) engine. The engine computes products and quotients bit-serially behind a start/done handshake, with saturation and divide-by-zero reporting. It sits between the ray-stepping FSM and the wall-distance/column-height logic, which issue one operation at a time.

## Interface
- INT_W, 10, integer bits including sign
- FRAC_W, 16, binary fraction bits; W = INT_W + FRAC_W; 1.0 = 2^FRAC_W
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request; accepted only when busy=0
- op  in  1  0 = multiply (a*b), 1 = divide (a/b)
- a  in  W  signed Q operand, sampled on accept edge
- b  in  W  signed Q operand, sampled on accept edge
- busy  out  1  high from accept edge until the FIN→IDLE edge
- done  out  1  one-cycle pulse; result and flags valid
- result  out  W  signed Q result, held until next done
- overflow  out  1  result saturated; held with result
- div_by_zero  out  1  divide with b=0; held with result

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - On start=1, latch |a|, |b| as W-bit unsigned magnitudes (|-2^(W-1)| = 2^(W-1)) and sign = a[W-1]^b[W-1].
  - Go to MUL (op=0), or DIV (op=1, b≠0). For op=1 with b=0, go directly to FIN.
- MUL: shift-add, one multiplier bit per cycle, N_MUL = W cycles; 2W-bit product P. Magnitude M = P >> FRAC_W (truncation toward zero).
- DIV: restoring division of (|a| << FRAC_W) by |b|, W+FRAC_W bits wide, one quotient bit per cycle, N_DIV = W+FRAC_W cycles; M = quotient (truncated toward zero).
- FIN: apply sign and saturate.
  - Positive result with M > 2^(W-1)-1 → 2^(W-1)-1, overflow=1.
  - Negative result with M > 2^(W-1) → -2^(W-1), overflow=1.
  - Otherwise result = ±M.
  - A zero magnitude always yields result 0, no overflow.
- Divide by zero: result = 2^(W-1)-1 if a ≥ 0, else -2^(W-1); div_by_zero=1, overflow=0.
- start while busy=1: ignored; no queueing, operands not re-sampled.
- start in the done cycle: accepted (state is IDLE).

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0, div_by_zero=0, state=IDLE, iteration counter=0.
- Accept edge k: busy=1 after k.
- Iterations occupy edges k+1..k+N; the state is FIN after edge k+N.
- Edge k+N+1: result/flags registered, done=1 for exactly one cycle, busy=0.
  - Multiply latency: W+1 edges.
  - Divide latency: W+FRAC_W+1 edges.
  - Divide by zero: 1 edge (done after k+1).
- Reset asserted mid-operation: immediate abort; no done pulse; outputs return to reset values.
- result/flags change only on the done edge or on reset.

## Structure
- Shared package fixed_point_pkg: op encodings (OP_MUL, OP_DIV), state encodings, and functions for Q_MAX = 2^(W-1)-1, Q_MIN = -2^(W-1), and ONE = 2^FRAC_W.
- One sub-module: fixed_point_sign_sat (combinational: magnitude, sign, width parameter → signed result + overflow), instantiated in FIN.
- Iteration counter width: clog2(W+FRAC_W+1).

## Test plan
All scenarios use defaults (W=26, 1.0=65536).
- Multiply: a=229376 (3.5), b=-131072 (-2.0) → result=-458752 (-7.0), overflow=0; done exactly 27 edges after accept.
- Divide: a=10485760 (160.0), b=24576 (0.375) → result=27962026 (426.6666), truncated; done 43 edges after accept.
- Divide by zero: a=-327680 (-5.0), b=0 → result=-33554432, div_by_zero=1, overflow=0; done 1 edge after accept. Repeat with a=0 → result=33554431.
- Saturation and boundary:
  - a=19660800 (300.0) * b=131072 (2.0) → result=33554431, overflow=1.
  - a=-33554432 (-512.0) * b=65536 → result=-33554432, overflow=0.
- Handshake: start pulsed again at iteration 5 with different operands → ignored, first result unchanged. Start asserted in the done cycle → accepted, second done 27 edges later.
- Reset mid-operation: reset at iteration 10 of a divide → busy=0 and all outputs 0 immediately; no done pulse; a subsequent multiply completes normally.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared encodings and Q-format constant helpers for the fixed-point mul/div engine.
package fixed_point_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Largest representable value of a w-bit signed Q number (raw integer).
    function automatic longint q_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Most negative representable value of a w-bit signed Q number (raw integer).
    function automatic longint q_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Raw encoding of 1.0 with frac_w fraction bits.
    function automatic longint q_one(input int frac_w);
        return longint'(1) <<< frac_w;
    endfunction

endpackage

// File: rtl/fixed_point_muldiv_seq_if.sv
// Request/response bundle between the ray-stepping logic and the mul/div engine.
interface fixed_point_muldiv_seq_if #(
    parameter int W = 26
);
    logic                start;
    logic                op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                busy;
    logic                done;
    logic signed [W-1:0] result;
    logic                overflow;
    logic                div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, overflow, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_sign_sat.sv
// Applies a sign to an unsigned magnitude and clamps it into a W-bit signed range.
module fixed_point_sign_sat
    import fixed_point_pkg::*;
#(
    parameter int W     = 26,
    parameter int MAG_W = 42
) (
    input  logic [MAG_W-1:0]    mag_i,
    input  logic                neg_i,
    output logic signed [W-1:0] result_o,
    output logic                overflow_o
);
    localparam logic [MAG_W-1:0]    LIM_POS = MAG_W'(q_max(W));
    localparam logic [MAG_W-1:0]    LIM_NEG = MAG_W'(-q_min(W));
    localparam logic signed [W-1:0] SAT_POS = W'(q_max(W));
    localparam logic signed [W-1:0] SAT_NEG = W'(q_min(W));

    // Negative side can reach one step further than the positive side.
    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        if (mag_i == '0) begin
            result_o = '0;
        end else if (!neg_i) begin
            if (mag_i > LIM_POS) begin
                result_o   = SAT_POS;
                overflow_o = 1'b1;
            end else begin
                result_o = mag_i[W-1:0];
            end
        end else begin
            if (mag_i > LIM_NEG) begin
                result_o   = SAT_NEG;
                overflow_o = 1'b1;
            end else begin
                result_o = -mag_i[W-1:0];
            end
        end
    end
endmodule

// File: rtl/fixed_point_muldiv_seq.sv
// Bit-serial signed Q(INT_W).(FRAC_W) multiply/divide engine with start/done handshake.
// Operates on magnitudes; sign and saturation are applied once in FIN.
module fixed_point_muldiv_seq
    import fixed_point_pkg::*;
#(
    parameter int INT_W  = 10,
    parameter int FRAC_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    fixed_point_muldiv_seq_if.slave   bus
);
    localparam int W     = INT_W + FRAC_W;
    localparam int N_MUL = W;
    localparam int N_DIV = W + FRAC_W;
    localparam int MAG_W = W + FRAC_W;
    localparam int CNT_W = $clog2(N_DIV + 1);

    localparam logic signed [W-1:0] SAT_POS = W'(q_max(W));
    localparam logic signed [W-1:0] SAT_NEG = W'(q_min(W));

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [W-1:0]        mag_a_q;
    logic [W-1:0]        mag_b_q;
    logic                neg_q;
    logic                neg_a_q;
    logic                op_q;
    logic                dz_q;
    // Multiply: {partial sum, remaining multiplier bits}, shifted right each step.
    logic [2*W-1:0]      acc_q;
    // Divide: dividend bits shift out the top while quotient bits shift in at the bottom.
    logic [N_DIV-1:0]    quo_q;
    logic [W-1:0]        rem_q;
    logic                busy_q;
    logic                done_q;
    logic signed [W-1:0] result_q;
    logic                overflow_q;
    logic                div_by_zero_q;

    logic [W-1:0]        abs_a;
    logic [W-1:0]        abs_b;
    logic [W:0]          mul_sum;
    logic [2*W-1:0]      acc_d;
    logic [W:0]          rem_sh;
    logic [W:0]          rem_diff;
    logic [W-1:0]        rem_d;
    logic [N_DIV-1:0]    quo_d;
    logic [MAG_W-1:0]    mag_fin;
    logic signed [W-1:0] sat_result;
    logic                sat_overflow;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1) as an unsigned W-bit value.
    always_comb begin
        abs_a = bus.a[W-1] ? W'(-bus.a) : W'(bus.a);
        abs_b = bus.b[W-1] ? W'(-bus.b) : W'(bus.b);
    end

    // One shift-add multiply step.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
        acc_d   = {mul_sum, acc_q[W-1:1]};
    end

    // One restoring-division step; a borrow in rem_diff means the trial subtract fails.
    always_comb begin
        rem_sh   = {rem_q, quo_q[N_DIV-1]};
        rem_diff = rem_sh - {1'b0, mag_b_q};
        rem_d    = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
        quo_d    = {quo_q[N_DIV-2:0], ~rem_diff[W]};
    end

    // Final magnitude: product truncated by FRAC_W, or the raw quotient.
    always_comb begin
        mag_fin = (op_q == OP_MUL) ? MAG_W'(acc_q[2*W-1:FRAC_W]) : quo_q;
    end

    fixed_point_sign_sat #(
        .W     (W),
        .MAG_W (MAG_W)
    ) u_sign_sat (
        .mag_i      (mag_fin),
        .neg_i      (neg_q),
        .result_o   (sat_result),
        .overflow_o (sat_overflow)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            neg_q         <= 1'b0;
            neg_a_q       <= 1'b0;
            op_q          <= OP_MUL;
            dz_q          <= 1'b0;
            acc_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mag_a_q <= abs_a;
                        mag_b_q <= abs_b;
                        neg_q   <= bus.a[W-1] ^ bus.b[W-1];
                        neg_a_q <= bus.a[W-1];
                        op_q    <= bus.op;
                        dz_q    <= (bus.op == OP_DIV) && (bus.b == '0);
                        acc_q   <= {{W{1'b0}}, abs_b};
                        quo_q   <= {abs_a, {FRAC_W{1'b0}}};
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        if (bus.op == OP_MUL)
                            state_q <= S_MUL;
                        else if (bus.b == '0)
                            state_q <= S_FIN;
                        else
                            state_q <= S_DIV;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_MUL - 1))
                        state_q <= S_FIN;
                end
                S_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_DIV - 1))
                        state_q <= S_FIN;
                end
                S_FIN: begin
                    if (dz_q) begin
                        result_q      <= neg_a_q ? SAT_NEG : SAT_POS;
                        overflow_q    <= 1'b0;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        result_q      <= sat_result;
                        overflow_q    <= sat_overflow;
                        div_by_zero_q <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_fixed_point_muldiv_seq.sv
// Scoreboard bench for fixed_point_muldiv_seq: stimulus pushes expectations from an
// arithmetic reference model, a negedge monitor pops and compares on every done pulse.
module tb_fixed_point_muldiv_seq;
    localparam int     INT_W  = 10;
    localparam int     FRAC_W = 16;
    localparam int     W      = INT_W + FRAC_W;
    localparam longint ONE    = 64'sd1 <<< FRAC_W;
    localparam longint QMAX   = (64'sd1 <<< (W - 1)) - 1;
    localparam longint QMIN   = -(64'sd1 <<< (W - 1));

    typedef struct {
        longint res;
        bit     ovf;
        bit     dz;
        int     lat;
        int     acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   prev_done = 1'b0;
    exp_t sbq[$];
    exp_t held = '{res: 0, ovf: 0, dz: 0, lat: 0, acc: 0};

    fixed_point_muldiv_seq_if #(.W(W)) bus ();

    fixed_point_muldiv_seq #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact rational result truncated toward zero, then clamped.
    function automatic exp_t model(input bit op, input longint a, input longint b);
        exp_t   e;
        longint m;
        e.acc = 0;
        e.dz  = 0;
        e.ovf = 0;
        if (op && b == 0) begin
            e.res = (a < 0) ? QMIN : QMAX;
            e.dz  = 1;
            e.lat = 1;
        end else begin
            m     = op ? (a * ONE) / b : (a * b) / ONE;
            e.lat = op ? (W + FRAC_W + 1) : (W + 1);
            if (m > QMAX) begin
                e.res = QMAX; e.ovf = 1;
            end else if (m < QMIN) begin
                e.res = QMIN; e.ovf = 1;
            end else begin
                e.res = m;
            end
        end
        return e;
    endfunction

    function automatic logic signed [W-1:0] rnd_opnd();
        logic signed [W-1:0] v;
        int unsigned         r;
        v = W'($urandom);
        r = $urandom_range(0, 6);
        case (r)
            2: v = v >>> 6;
            3: v = v >>> 14;
            4: v = '0;
            5: v = ($urandom_range(0, 1) == 1) ? W'(QMIN) : W'(QMAX);
            6: v = ($urandom_range(0, 1) == 1) ? W'(ONE) : W'(-ONE);
            default: ;
        endcase
        return v;
    endfunction

    // Called at a negedge; waits for idle, drives start for one cycle, records expectation.
    task automatic issue(input bit op, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e         = model(op, longint'(a), longint'(b));
        e.acc     = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Monitor: compare every done against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.done) begin
                chk("done_pulse_width", prev_done, 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("result", bus.result, e.res);
                    chk("overflow", bus.overflow, e.ovf);
                    chk("div_by_zero", bus.div_by_zero, e.dz);
                    chk("busy_at_done", bus.busy, 0);
                    chk("latency", cyc - e.acc, e.lat);
                    held = e;
                end
            end else if (bus.busy) begin
                chk("result_hold", bus.result, held.res);
                chk("flags_hold", {bus.overflow, bus.div_by_zero}, {held.ovf, held.dz});
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        int t;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, issued back-to-back so each start lands in the previous done cycle.
        issue(1'b0, 26'sd229376, -26'sd131072);
        issue(1'b1, 26'sd10485760, 26'sd24576);
        issue(1'b1, -26'sd327680, 26'sd0);
        issue(1'b1, 26'sd0, 26'sd0);
        issue(1'b0, 26'sd19660800, 26'sd131072);
        issue(1'b0, -26'sd33554432, 26'sd65536);

        // A start while busy must be ignored.
        issue(1'b0, 26'sd229376, 26'sd196608);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = -26'sd65536;
        bus.b     = 26'sd0;
        @(negedge clk);
        bus.start = 1'b0;

        // Abort a divide mid-flight.
        issue(1'b1, 26'sd10485760, 26'sd24576);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_overflow", bus.overflow, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        void'(sbq.pop_back());
        held = '{res: 0, ovf: 0, dz: 0, lat: 0, acc: 0};
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        issue(1'b0, -26'sd98304, 26'sd163840);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            logic signed [W-1:0] ra;
            logic signed [W-1:0] rb;
            ra = rnd_opnd();
            rb = rnd_opnd();
            issue($urandom_range(0, 1) == 1, ra, rb);
        end

        t = 0;
        while ((sbq.size() != 0 || bus.busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", sbq.size(), 0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
